// File: rtl/spi_byte_fifo_pkg.sv
// Shared register map, STATUS/IE bit positions and address decode for the SPI byte FIFO stage.
package spi_byte_fifo_pkg;

  localparam logic [15:0] ADDR_TXDATA = 16'h0000;
  localparam logic [15:0] ADDR_RXDATA = 16'h0004;
  localparam logic [15:0] ADDR_STATUS = 16'h0008;
  localparam logic [15:0] ADDR_IE     = 16'h000C;
  localparam logic [15:0] ADDR_FLUSH  = 16'h0010;

  localparam int ST_TX_EMPTY   = 0;
  localparam int ST_TX_FULL    = 1;
  localparam int ST_RX_EMPTY   = 2;
  localparam int ST_RX_FULL    = 3;
  localparam int ST_RX_OVF     = 4;
  localparam int ST_TX_OVF     = 5;
  localparam int ST_TX_CNT_LSB = 8;
  localparam int ST_RX_CNT_LSB = 16;

  localparam int IE_TX_EMPTY = 0;
  localparam int IE_RX_AVAIL = 1;
  localparam int IE_OVF      = 2;

  localparam int FLUSH_TX_BIT = 0;
  localparam int FLUSH_RX_BIT = 1;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_TXDATA,
    REG_RXDATA,
    REG_STATUS,
    REG_IE,
    REG_FLUSH
  } reg_sel_e;

  // Full 16-bit compare so aliases of the map never select a register.
  function automatic reg_sel_e decode_addr(input logic [15:0] addr);
    reg_sel_e sel;
    sel = REG_NONE;
    case (addr)
      ADDR_TXDATA: sel = REG_TXDATA;
      ADDR_RXDATA: sel = REG_RXDATA;
      ADDR_STATUS: sel = REG_STATUS;
      ADDR_IE:     sel = REG_IE;
      ADDR_FLUSH:  sel = REG_FLUSH;
      default:     sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/spi_byte_fifo_sync.sv
// Single-clock byte FIFO with show-ahead head, occupancy count and flush.
// A push into a full FIFO is still accepted when a pop happens on the same edge.
module sync_byte_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [7:0]       din,
  output logic [7:0]       head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  logic [7:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  // A flushed byte is discarded, not counted as an overflow.
  assign drop    = push & ~push_ok & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/spi_byte_fifo.sv
// Register-mapped TX/RX byte FIFOs in front of the SPI shift engine, with sticky
// overflow flags, interrupt enables and a registered level interrupt.
module spi_byte_fifo
  import spi_byte_fifo_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] rw_addr,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        irq
);

  reg_sel_e         sel;
  logic             wr_ok;
  logic             tx_push, tx_flush, tx_full, tx_empty, tx_drop;
  logic             rx_pop, rx_flush, rx_full, rx_empty, rx_drop;
  logic [CNT_W-1:0] tx_count, rx_count;
  logic [7:0]       rx_head;
  logic [31:0]      status;
  logic             unused_wr_bits;

  logic [2:0] ie_q, ie_d;
  logic       tx_ovf_q, tx_ovf_d;
  logic       rx_ovf_q, rx_ovf_d;
  logic       irq_q, irq_d;

  assign sel      = decode_addr(rw_addr);
  assign wr_ok    = wr_en & (wr_strb == 4'b1111);
  assign tx_push  = wr_ok & (sel == REG_TXDATA);
  assign rx_pop   = rd_en & (sel == REG_RXDATA);
  assign tx_flush = wr_ok & (sel == REG_FLUSH) & wr_data[FLUSH_TX_BIT];
  assign rx_flush = wr_ok & (sel == REG_FLUSH) & wr_data[FLUSH_RX_BIT];
  assign unused_wr_bits = ^wr_data[31:8];

  sync_byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_ready),
    .flush (tx_flush),
    .din   (wr_data[7:0]),
    .head  (tx_data),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty),
    .drop  (tx_drop)
  );

  sync_byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_valid),
    .pop   (rx_pop),
    .flush (rx_flush),
    .din   (rx_data),
    .head  (rx_head),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty),
    .drop  (rx_drop)
  );

  assign tx_valid = ~tx_empty;
  assign irq      = irq_q;

  always_comb begin
    status                         = '0;
    status[ST_TX_EMPTY]            = tx_empty;
    status[ST_TX_FULL]             = tx_full;
    status[ST_RX_EMPTY]            = rx_empty;
    status[ST_RX_FULL]             = rx_full;
    status[ST_RX_OVF]              = rx_ovf_q;
    status[ST_TX_OVF]              = tx_ovf_q;
    status[ST_TX_CNT_LSB +: 8]     = 8'(tx_count);
    status[ST_RX_CNT_LSB +: 8]     = 8'(rx_count);
  end

  // Read mux is purely address-decoded; an empty RX FIFO reads as zero.
  always_comb begin
    rd_data = '0;
    case (sel)
      REG_RXDATA: rd_data = rx_empty ? 32'd0 : {24'd0, rx_head};
      REG_STATUS: rd_data = status;
      REG_IE:     rd_data = {29'd0, ie_q};
      default:    rd_data = '0;
    endcase
  end

  // Overflow set is applied after the W1C clear so a coincident set survives.
  always_comb begin
    ie_d     = ie_q;
    tx_ovf_d = tx_ovf_q;
    rx_ovf_d = rx_ovf_q;
    if (wr_ok && sel == REG_IE) ie_d = wr_data[2:0];
    if (wr_ok && sel == REG_STATUS) begin
      if (wr_data[ST_TX_OVF]) tx_ovf_d = 1'b0;
      if (wr_data[ST_RX_OVF]) rx_ovf_d = 1'b0;
    end
    if (tx_drop) tx_ovf_d = 1'b1;
    if (rx_drop) rx_ovf_d = 1'b1;
    irq_d = (ie_q[IE_TX_EMPTY] & tx_empty)
          | (ie_q[IE_RX_AVAIL] & ~rx_empty)
          | (ie_q[IE_OVF] & (rx_ovf_q | tx_ovf_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ie_q     <= '0;
      tx_ovf_q <= 1'b0;
      rx_ovf_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      ie_q     <= ie_d;
      tx_ovf_q <= tx_ovf_d;
      rx_ovf_q <= rx_ovf_d;
      irq_q    <= irq_d;
    end
  end

endmodule

// File: tb/tb_spi_byte_fifo.sv
// Directed and randomized checks of spi_byte_fifo against a queue-based reference model.
module tb_spi_byte_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] rw_addr;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        rd_en;
  logic [31:0] rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        irq;

  always #5 clk = ~clk;

  spi_byte_fifo #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .rw_addr  (rw_addr),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .wr_strb  (wr_strb),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .irq      (irq)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic       m_tx_ovf, m_rx_ovf, m_irq;
  logic [2:0] m_ie;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    tx_q.delete();
    rx_q.delete();
    m_tx_ovf = 1'b0;
    m_rx_ovf = 1'b0;
    m_irq    = 1'b0;
    m_ie     = 3'd0;
  endtask

  function automatic logic [31:0] model_read(input logic [15:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      16'h0004: if (rx_q.size() > 0) v = {24'd0, rx_q[0]};
      16'h0008: begin
        v[0]     = (tx_q.size() == 0);
        v[1]     = (tx_q.size() == DEPTH);
        v[2]     = (rx_q.size() == 0);
        v[3]     = (rx_q.size() == DEPTH);
        v[4]     = m_rx_ovf;
        v[5]     = m_tx_ovf;
        v[15:8]  = 8'(tx_q.size());
        v[23:16] = 8'(rx_q.size());
      end
      16'h000C: v[2:0] = m_ie;
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic idle_inputs();
    rw_addr  = 16'h0;
    wr_en    = 1'b0;
    wr_data  = 32'h0;
    wr_strb  = 4'h0;
    rd_en    = 1'b0;
    tx_ready = 1'b0;
    rx_data  = 8'h0;
    rx_valid = 1'b0;
  endtask

  // One bus cycle: check registered outputs, drive, check read data, advance the model.
  task automatic step(input logic [15:0] addr, input logic we, input logic [31:0] wd,
                      input logic [3:0] strb, input logic re, input logic rxv,
                      input logic [7:0] rxd, input logic txr, output logic [31:0] rdv);
    int  tsz, rsz;
    bit  wok, tpop, rpop, ft, fr, irq_n, txo, rxo;
    @(negedge clk);
    check("tx_valid", {31'd0, tx_valid}, {31'd0, tx_q.size() != 0});
    if (tx_q.size() != 0) check("tx_data", {24'd0, tx_data}, {24'd0, tx_q[0]});
    check("irq", {31'd0, irq}, {31'd0, m_irq});
    rw_addr = addr; wr_en = we; wr_data = wd; wr_strb = strb;
    rd_en = re; rx_valid = rxv; rx_data = rxd; tx_ready = txr;
    #1;
    rdv = rd_data;
    if (re) check("rd_data", rd_data, model_read(addr));
    tsz   = tx_q.size();
    rsz   = rx_q.size();
    wok   = we && (strb == 4'hF);
    tpop  = txr && (tsz > 0);
    rpop  = re && (addr == 16'h0004) && (rsz > 0);
    ft    = wok && (addr == 16'h0010) && wd[0];
    fr    = wok && (addr == 16'h0010) && wd[1];
    irq_n = (m_ie[0] && tsz == 0) || (m_ie[1] && rsz > 0) || (m_ie[2] && (m_tx_ovf || m_rx_ovf));
    txo   = m_tx_ovf;
    rxo   = m_rx_ovf;
    if (wok && addr == 16'h0008) begin
      if (wd[5]) txo = 1'b0;
      if (wd[4]) rxo = 1'b0;
    end
    if (ft) tx_q.delete();
    else begin
      if (tpop) void'(tx_q.pop_front());
      if (wok && addr == 16'h0000) begin
        if (tsz < DEPTH || tpop) tx_q.push_back(wd[7:0]);
        else txo = 1'b1;
      end
    end
    if (fr) rx_q.delete();
    else begin
      if (rpop) void'(rx_q.pop_front());
      if (rxv) begin
        if (rsz < DEPTH || rpop) rx_q.push_back(rxd);
        else rxo = 1'b1;
      end
    end
    if (wok && addr == 16'h000C) m_ie = wd[2:0];
    m_tx_ovf = txo;
    m_rx_ovf = rxo;
    m_irq    = irq_n;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic txr);
    logic [31:0] dummy;
    step(a, 1'b1, d, 4'hF, 1'b0, 1'b0, 8'h0, txr, dummy);
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] v);
    step(a, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 8'h0, 1'b0, v);
  endtask

  task automatic idle(input logic txr);
    logic [31:0] dummy;
    step(16'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 8'h0, txr, dummy);
  endtask

  task automatic rx_push(input logic [7:0] d);
    logic [31:0] dummy;
    step(16'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, d, 1'b0, dummy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic [15:0] a;
    logic        we, re;
    logic [31:0] wd;
    logic [3:0]  strb;
    int          sel;

    rst = 1'b1;
    idle_inputs();
    model_reset();
    do_reset();

    // Reset state
    rd(16'h0008, r);
    check("t1_status", r, 32'h0000_0005);
    check("t1_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("t1_irq", {31'd0, irq}, 32'd0);

    // Two bytes through TX with the engine always ready
    wr(16'h0000, 32'hA5, 1'b1);
    check("t2_first", {24'd0, tx_data}, 32'hA5);
    wr(16'h0000, 32'h3C, 1'b1);
    check("t2_second", {24'd0, tx_data}, 32'h3C);
    idle(1'b1);
    check("t2_drained", {31'd0, tx_valid}, 32'd0);
    rd(16'h0008, r);
    check("t2_status", r, 32'h0000_0005);

    // TX overflow and drain order
    for (int i = 0; i < 17; i++) wr(16'h0000, 32'(i), 1'b0);
    rd(16'h0008, r);
    check("t3_status", r, 32'h0000_1026);
    for (int i = 0; i < 16; i++) begin
      check("t3_drain", {24'd0, tx_data}, 32'(i));
      idle(1'b1);
    end
    check("t3_empty", {31'd0, tx_valid}, 32'd0);
    wr(16'h0008, 32'h20, 1'b0);
    rd(16'h0008, r);
    check("t3_w1c", r, 32'h0000_0005);

    // RX overflow and read-out order
    for (int i = 0; i < 20; i++) rx_push(8'(8'h80 + i));
    rd(16'h0008, r);
    check("t4_status", r, 32'h0010_0019);
    for (int i = 0; i < 16; i++) begin
      rd(16'h0004, r);
      check("t4_read", r, 32'(8'h80 + i));
    end
    rd(16'h0004, r);
    check("t4_empty_read", r, 32'h0);
    wr(16'h0008, 32'h10, 1'b0);

    // RX-available interrupt latency
    wr(16'h000C, 32'h2, 1'b0);
    rx_push(8'h55);
    check("t5_irq_e0", {31'd0, irq}, 32'd0);
    idle(1'b0);
    check("t5_irq_set", {31'd0, irq}, 32'd1);
    rd(16'h0004, r);
    check("t5_rx", r, 32'h55);
    check("t5_irq_f0", {31'd0, irq}, 32'd1);
    idle(1'b0);
    check("t5_irq_clr", {31'd0, irq}, 32'd0);
    wr(16'h000C, 32'h0, 1'b0);

    // Full RX with coincident push/pop, set-beats-clear, flush
    wr(16'h0000, 32'h11, 1'b0);
    wr(16'h0000, 32'h22, 1'b0);
    for (int i = 0; i < 16; i++) rx_push(8'(8'h10 + i));
    step(16'h0004, 1'b0, 32'h0, 4'h0, 1'b1, 1'b1, 8'hEE, 1'b0, r);
    check("t6_pushpop_rd", r, 32'h10);
    rd(16'h0008, r);
    check("t6_no_ovf", r, 32'h0010_0208);
    step(16'h0008, 1'b1, 32'h10, 4'hF, 1'b0, 1'b1, 8'hEF, 1'b0, r);
    rd(16'h0008, r);
    check("t6_set_wins", r, 32'h0010_0218);
    step(16'h0010, 1'b1, 32'h3, 4'hF, 1'b0, 1'b1, 8'h77, 1'b0, r);
    check("t6_flush_txv", {31'd0, tx_valid}, 32'd0);
    rd(16'h0008, r);
    check("t6_flush", r, 32'h0000_0015);
    wr(16'h0008, 32'h30, 1'b0);

    // IE readback and partial-strobe writes ignored
    wr(16'h000C, 32'h7, 1'b0);
    step(16'h000C, 1'b1, 32'h0, 4'b0111, 1'b0, 1'b0, 8'h0, 1'b0, r);
    rd(16'h000C, r);
    check("ie_readback", r, 32'h7);
    rd(16'h0014, r);
    check("unmapped_rd", r, 32'h0);
    wr(16'h000C, 32'h0, 1'b0);

    // Reset with TX data pending
    for (int i = 0; i < 3; i++) wr(16'h0000, 32'(8'hC0 + i), 1'b0);
    do_reset();
    rd(16'h0008, r);
    check("rst_mid_status", r, 32'h0000_0005);

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      sel  = $urandom_range(0, 9);
      we   = 1'b0;
      re   = 1'b0;
      wd   = $urandom;
      a    = 16'h0;
      strb = ($urandom_range(0, 7) == 0) ? 4'b1011 : 4'hF;
      case (sel)
        0, 1, 2, 3: begin a = 16'h0000; we = 1'b1; end
        4, 5:       begin a = 16'h0004; re = 1'b1; end
        6:          begin a = 16'h0008; re = 1'b1; end
        7:          begin a = 16'h0008; we = 1'b1; end
        8:          begin a = 16'h000C; we = ($urandom_range(0, 1) == 0); re = ~we; end
        default: begin
          if ($urandom_range(0, 7) == 0) begin a = 16'h0010; we = 1'b1; end
          else begin a = 16'h0014; re = 1'b1; end
        end
      endcase
      step(a, we, wd, strb, re, 1'($urandom_range(0, 1)), 8'($urandom),
           ($urandom_range(0, 3) == 0), r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
